// File: rtl/shift_sequencer.sv
// Two-requester round-robin shift/rotate unit. By default it shifts one bit per clock.
// Defining SHIFT_SEQ_BARREL_EN switches to a single-cycle barrel datapath.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [15:0]      req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [15:0]      req1_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             out_err,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         op_reg, op_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               id_reg, id_next;
  logic               err_reg, err_next;
  logic               rr_last_reg, rr_last_next;

  logic               grant;
  logic               accept;
  logic [2:0]         sel_op;
  logic [WIDTH-1:0]   sel_data;
  logic [15:0]        sel_amt;
  logic [CNT_W-1:0]   sel_cnt;
  logic [WIDTH-1:0]   step;

  // When both are valid, the requester that did not win last time gets the grant.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~rr_last_reg;
    else                          grant = req1_valid;
  end

  assign req0_ready = rst & (state_reg == IDLE) & ~grant & req0_valid;
  assign req1_ready = rst & (state_reg == IDLE) &  grant & req1_valid;
  assign accept     = req0_ready | req1_ready;

  assign sel_op   = grant ? req1_op   : req0_op;
  assign sel_data = grant ? req1_data : req0_data;
  assign sel_amt  = grant ? req1_amt  : req0_amt;

  // Shifts saturate at WIDTH. Rotates wrap modulo WIDTH.
  always_comb begin
    case (sel_op)
      3'd0, 3'd1, 3'd2:
        sel_cnt = (sel_amt >= 16'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(sel_amt);
      3'd3, 3'd4:
        sel_cnt = CNT_W'(sel_amt[SH_W-1:0]);
      default:
        sel_cnt = '0;
    endcase
  end

  always_comb begin
    step = work_reg;
    case (op_reg)
      3'd0:    step = {work_reg[WIDTH-2:0], 1'b0};
      3'd1:    step = {1'b0, work_reg[WIDTH-1:1]};
      3'd2:    step = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
      3'd3:    step = {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};
      3'd4:    step = {work_reg[0], work_reg[WIDTH-1:1]};
      default: step = work_reg;
    endcase
  end

`ifdef SHIFT_SEQ_BARREL_EN
  // Stage gi applies a shift of 2**gi when bit gi of the count is set.
  logic [WIDTH-1:0] stage [0:CNT_W];
  assign stage[0] = sel_data;
  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_barrel
    localparam int K = 1 << gi;
    logic [WIDTH-1:0] lsl_v, lsr_v, asr_v, rol_v, ror_v, sel_v;
    assign lsl_v = stage[gi] << K;
    assign lsr_v = stage[gi] >> K;
    assign asr_v = WIDTH'($signed(stage[gi]) >>> K);
    assign rol_v = (stage[gi] << K) | (stage[gi] >> (WIDTH - K));
    assign ror_v = (stage[gi] >> K) | (stage[gi] << (WIDTH - K));
    assign sel_v = (sel_op == 3'd0) ? lsl_v :
                   (sel_op == 3'd1) ? lsr_v :
                   (sel_op == 3'd2) ? asr_v :
                   (sel_op == 3'd3) ? rol_v :
                   (sel_op == 3'd4) ? ror_v : stage[gi];
    assign stage[gi+1] = sel_cnt[gi] ? sel_v : stage[gi];
  end
`endif

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    work_next    = work_reg;
    cnt_next     = cnt_reg;
    id_next      = id_reg;
    err_next     = err_reg;
    rr_last_next = rr_last_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next      = sel_op;
          id_next      = grant;
          err_next     = (sel_op > 3'd4);
          rr_last_next = grant;
`ifdef SHIFT_SEQ_BARREL_EN
          work_next    = stage[CNT_W];
          cnt_next     = '0;
          state_next   = DONE;
`else
          work_next    = sel_data;
          cnt_next     = sel_cnt;
          state_next   = (sel_cnt != '0) ? EXEC : DONE;
`endif
        end
      end
      EXEC: begin
        work_next = step;
        cnt_next  = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      work_reg    <= '0;
      cnt_reg     <= '0;
      id_reg      <= 1'b0;
      err_reg     <= 1'b0;
      rr_last_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      work_reg    <= work_next;
      cnt_reg     <= cnt_next;
      id_reg      <= id_next;
      err_reg     <= err_next;
      rr_last_reg <= rr_last_next;
    end
  end

  assign out_valid = (state_reg == DONE);
  assign out_data  = work_reg;
  assign out_id    = id_reg;
  assign out_err   = err_reg;
  assign busy      = (state_reg != IDLE);

endmodule
